// File: rtl/obstacle_pool_if.sv
// Control and slot-readout bundle between the game logic and obstacle_pool.
// The master side is the game FSM / tick logic; the slave side is the pool itself.
interface obstacle_pool_if #(
   parameter int NUM_SLOTS = 4,
   parameter int X_W       = 13,
   parameter int TYPE_W    = 2,
   parameter int SCORE_W   = 10
);
   logic                        frame_tick;
   logic                        run;
   logic                        clear;
   logic [15:0]                 rand_in;
   logic [9:0]                  player_y;
   logic [NUM_SLOTS-1:0]        obj_active;
   logic [NUM_SLOTS*X_W-1:0]    obj_x;
   logic [NUM_SLOTS*TYPE_W-1:0] obj_type;
   logic [SCORE_W-1:0]          score;
   logic [4:0]                  speed;
   logic                        hit;
   logic                        busy;
   logic                        frame_done;
   logic                        overrun;

   modport master (
      output frame_tick, run, clear, rand_in, player_y,
      input  obj_active, obj_x, obj_type, score, speed, hit, busy, frame_done, overrun
   );

   modport slave (
      input  frame_tick, run, clear, rand_in, player_y,
      output obj_active, obj_x, obj_type, score, speed, hit, busy, frame_done, overrun
   );
endinterface

// File: rtl/obstacle_pool.sv
// Obstacle slot pool: per-frame sequential walk (MOVE, SPAWN, HIT, DONE) over NUM_SLOTS slots.
// Define OBSTACLE_FLYING_EN to treat the all-ones type as a flying obstacle with a raised hit box.
module obstacle_pool #(
   parameter int NUM_SLOTS   = 4,
   parameter int X_W         = 13,
   parameter int SPAWN_X     = 640,
   parameter int DESPAWN_X   = -40,
   parameter int MIN_GAP     = 250,
   parameter int GAP_RAND_W  = 9,
   parameter int OBJ_W       = 18,
   parameter int OBJ_H       = 18,
   parameter int PLAYER_X    = 80,
   parameter int PLAYER_W    = 18,
   parameter int PLAYER_H    = 18,
   parameter int GROUND_Y    = 350,
   parameter int FLY_ALT     = 30,
   parameter int TYPE_W      = 2,
   parameter int SCORE_W     = 10,
   parameter int BASE_SPEED  = 4,
   parameter int SPEED_SHIFT = 4,
   parameter int MAX_SPEED   = 15
) (
   input logic            pclk,
   input logic            rst,
   obstacle_pool_if.slave bus
);
   localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int SW    = X_W + 2;
   localparam int SPW   = SCORE_W + 6;
   typedef logic signed [SW-1:0] sx_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
   localparam sx_t DESPAWN_S = sx_t'(DESPAWN_X);
   localparam sx_t PL_L      = sx_t'(PLAYER_X);
   localparam sx_t PL_R      = sx_t'(PLAYER_X + PLAYER_W);
   localparam sx_t PL_HS     = sx_t'(PLAYER_H);
   localparam sx_t OBJ_WS    = sx_t'(OBJ_W);
   localparam sx_t GAP_BASE  = sx_t'(SPAWN_X - MIN_GAP);
   localparam sx_t GND_TOP   = sx_t'(GROUND_Y - OBJ_H);
   localparam sx_t GND_BOT   = sx_t'(GROUND_Y);
   localparam sx_t FLY_TOP   = sx_t'(GROUND_Y - FLY_ALT - OBJ_H);
   localparam sx_t FLY_BOT   = sx_t'(GROUND_Y - FLY_ALT);

   typedef enum logic [2:0] {IDLE, MOVE, SPAWN, HIT, DONE} state_t;

   state_t                            state_q;
   logic [IDX_W-1:0]                  idx_q;
   logic [IDX_W-1:0]                  last_q;
   logic [GAP_RAND_W-1:0]             gap_q;
   logic [NUM_SLOTS-1:0]              active_q;
   logic [NUM_SLOTS-1:0][X_W-1:0]     x_q;
   logic [NUM_SLOTS-1:0][TYPE_W-1:0]  type_q;
   logic [SCORE_W-1:0]                score_q;
   logic [4:0]                        speed_q;
   logic                              hit_q;
   logic                              busy_q;
   logic                              done_q;
   logic                              ovr_q;

   // Slot under the walk cursor: move result, pass/despawn tests, hit box.
   logic signed [X_W-1:0] cur_x;
   logic signed [X_W-1:0] new_x;
   logic signed [X_W-1:0] last_x;
   sx_t                   cur_e;
   sx_t                   new_e;
   sx_t                   gap_thr;
   sx_t                   py_e;
   sx_t                   box_top;
   sx_t                   box_bot;
   logic                  pass;
   logic                  despawn;
   logic                  overlap;
   logic                  is_fly;
   logic [IDX_W-1:0]      nxt_idx;
   logic                  spawn_ok;
   logic [SPW-1:0]        spd_sum;
   logic [4:0]            speed_d;
   logic [GAP_RAND_W+7:0] rand_ext;
   logic                  unused_rand;

   assign cur_x   = x_q[idx_q];
   assign new_x   = cur_x - X_W'(speed_q);
   assign cur_e   = sx_t'(cur_x);
   assign new_e   = sx_t'(new_x);
   assign pass    = (cur_e + OBJ_WS > PL_L) && (new_e + OBJ_WS <= PL_L);
   assign despawn = new_e < DESPAWN_S;

   assign nxt_idx  = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
   assign last_x   = x_q[last_q];
   assign gap_thr  = GAP_BASE - sx_t'(gap_q);
   assign spawn_ok = (~|active_q || sx_t'(last_x) < gap_thr) && !active_q[nxt_idx];

   // Gap field may reach past bit 15 of rand_in; those bits read as zero.
   assign rand_ext    = (GAP_RAND_W + 8)'(bus.rand_in);
   assign unused_rand = ^{bus.rand_in, rand_ext[7:0]};

`ifdef OBSTACLE_FLYING_EN
   assign is_fly = &type_q[idx_q];
`else
   assign is_fly = 1'b0;
`endif

   assign py_e    = sx_t'(bus.player_y);
   assign box_top = is_fly ? FLY_TOP : GND_TOP;
   assign box_bot = is_fly ? FLY_BOT : GND_BOT;
   assign overlap = (cur_e < PL_R) && (cur_e + OBJ_WS > PL_L) &&
                    (py_e < box_bot) && (py_e + PL_HS > box_top);

   assign spd_sum = SPW'(BASE_SPEED) + SPW'(score_q >> SPEED_SHIFT);
   assign speed_d = (spd_sum > SPW'(MAX_SPEED)) ? 5'(MAX_SPEED) : spd_sum[4:0];

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         last_q   <= LAST_IDX;
         gap_q    <= '0;
         active_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]    <= X_W'(SPAWN_X);
            type_q[i] <= '0;
         end
         score_q  <= '0;
         speed_q  <= 5'(BASE_SPEED);
         hit_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else if (bus.clear) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         last_q   <= LAST_IDX;
         gap_q    <= '0;
         active_q <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            x_q[i]    <= X_W'(SPAWN_X);
            type_q[i] <= '0;
         end
         score_q  <= '0;
         hit_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // A tick only counts as an overrun when it would otherwise have started a walk.
         if (bus.frame_tick && bus.run && state_q != IDLE) ovr_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (bus.frame_tick && bus.run) begin
                  state_q <= MOVE;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            MOVE: begin
               if (active_q[idx_q]) begin
                  x_q[idx_q] <= new_x;
                  if (despawn) active_q[idx_q] <= 1'b0;
                  if (pass && score_q != '1) score_q <= score_q + 1'b1;
               end
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= SPAWN;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            SPAWN: begin
               if (spawn_ok) begin
                  active_q[nxt_idx] <= 1'b1;
                  x_q[nxt_idx]      <= X_W'(SPAWN_X);
                  type_q[nxt_idx]   <= bus.rand_in[TYPE_W-1:0];
                  last_q            <= nxt_idx;
                  gap_q             <= rand_ext[GAP_RAND_W+7:8];
               end
               state_q <= HIT;
            end
            HIT: begin
               if (active_q[idx_q] && overlap) hit_q <= 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  speed_q <= speed_d;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.obj_active = active_q;
   assign bus.obj_x      = x_q;
   assign bus.obj_type   = type_q;
   assign bus.score      = score_q;
   assign bus.speed      = speed_q;
   assign bus.hit        = hit_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
   assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_obstacle_pool.sv
// Scoreboarded bench for obstacle_pool: frame-level expectations queued at each tick,
// compared by a monitor on frame_done; a second small instance exercises score saturation.
module tb_obstacle_pool;
   logic   pclk = 1'b0;
   logic   rst  = 1'b1;
   longint cyc  = 0;
   int     errors = 0;
   int     checks = 0;

`ifdef OBSTACLE_FLYING_EN
   localparam bit FLY = 1'b1;
`else
   localparam bit FLY = 1'b0;
`endif

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc++;

   obstacle_pool_if bus ();
   obstacle_pool dut (.pclk(pclk), .rst(rst), .bus(bus));

   obstacle_pool_if #(.SCORE_W(4)) bus2 ();
   obstacle_pool #(.SCORE_W(4), .SPAWN_X(100), .MIN_GAP(20), .SPEED_SHIFT(0))
      dut2 (.pclk(pclk), .rst(rst), .bus(bus2));

   typedef struct {
      logic [3:0]       act;
      logic [3:0][15:0] x;
      logic [3:0][1:0]  ty;
      int               score;
      int               speed;
      bit               hit;
      bit               ovr;
      longint           t0;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   bcnt = 0;

   bit m_act[4];
   int m_x[4];
   int m_ty[4];
   int m_score, m_speed, m_last, m_gap;
   bit m_hit, m_ovr;

   function automatic void chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endfunction

   function automatic int slot_x(int i);
      logic signed [12:0] v;
      v = bus.obj_x[i*13 +: 13];
      return int'(v);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_act[i] = 0; m_x[i] = 640; m_ty[i] = 0;
      end
      m_score = 0; m_last = 3; m_gap = 0; m_hit = 0; m_ovr = 0;
   endtask

   task automatic model_frame(input int py, input int rnd, input bit dbl);
      exp_t e;
      int   ox, nx, nxt, top, bot;
      bit   any, fly;
      for (int i = 0; i < 4; i++) begin
         if (m_act[i]) begin
            ox = m_x[i];
            nx = ox - m_speed;
            m_x[i] = nx;
            if (nx < -40) m_act[i] = 0;
            if (ox + 18 > 80 && nx + 18 <= 80 && m_score < 1023) m_score++;
         end
      end
      nxt = (m_last + 1) % 4;
      any = m_act[0] | m_act[1] | m_act[2] | m_act[3];
      if ((!any || m_x[m_last] < 390 - m_gap) && !m_act[nxt]) begin
         m_act[nxt] = 1; m_x[nxt] = 640; m_ty[nxt] = rnd % 4;
         m_last = nxt; m_gap = (rnd >> 8) & 511;
      end
      for (int i = 0; i < 4; i++) begin
         if (m_act[i]) begin
            fly = FLY && m_ty[i] == 3;
            top = fly ? 302 : 332;
            bot = fly ? 320 : 350;
            if (m_x[i] < 98 && m_x[i] + 18 > 80 && py < bot && py + 18 > top) m_hit = 1;
         end
      end
      m_speed = 4 + (m_score >> 4);
      if (m_speed > 15) m_speed = 15;
      if (dbl) m_ovr = 1;
      for (int i = 0; i < 4; i++) begin
         e.act[i] = m_act[i];
         e.x[i]   = 16'(m_x[i]);
         e.ty[i]  = 2'(m_ty[i]);
      end
      e.score = m_score; e.speed = m_speed; e.hit = m_hit; e.ovr = m_ovr; e.t0 = cyc;
      q.push_back(e);
   endtask

   // Monitor: every frame_done pops one expectation.
   always @(negedge pclk) begin
      if (rst) begin
         bcnt = 0;
      end else begin
         if (bus.busy) bcnt++; else bcnt = 0;
         if (bus.frame_done) begin
            if (q.size() == 0) begin
               chk("unexpected_frame_done", 1, 0);
            end else begin
               me = q.pop_front();
               chk("done_latency", cyc - me.t0, 10);
               chk("busy_cycles", bcnt, 10);
               chk("obj_active", bus.obj_active, me.act);
               for (int i = 0; i < 4; i++) begin
                  if (me.act[i]) begin
                     chk("obj_x", slot_x(i), int'($signed(me.x[i])));
                     chk("obj_type", bus.obj_type[i*2 +: 2], me.ty[i]);
                  end
               end
               chk("score", bus.score, me.score);
               chk("speed", bus.speed, me.speed);
               chk("hit", bus.hit, me.hit);
               chk("overrun", bus.overrun, me.ovr);
            end
         end
      end
   end

   task automatic send_frame(input int py, input int rnd, input bit dbl, input bit drop_run);
      bit got;
      got = 0;
      bus.player_y   = 10'(py);
      bus.rand_in    = 16'(rnd);
      bus.frame_tick = 1;
      model_frame(py, rnd, dbl);
      @(posedge pclk); #1;
      bus.frame_tick = 0;
      if (drop_run) bus.run = 0;
      if (dbl) begin
         @(posedge pclk); #1;
         @(posedge pclk); #1;
         bus.frame_tick = 1;
         @(posedge pclk); #1;
         bus.frame_tick = 0;
      end
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge pclk);
         got = bus.frame_done;
      end
      if (!got) chk("frame_timeout", 0, 1);
      @(posedge pclk); #1;
   endtask

   task automatic pulse_clear();
      bus.clear = 1;
      @(posedge pclk); #1;
      bus.clear = 0;
      model_clear();
   endtask

   task automatic idle_busy_count(input int n, output int seen);
      seen = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge pclk);
         if (bus.busy) seen++;
      end
      @(posedge pclk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      bus.frame_tick = 0; bus.run = 0; bus.clear = 0; bus.rand_in = 0; bus.player_y = 200;
      bus2.frame_tick = 0; bus2.run = 0; bus2.clear = 0; bus2.rand_in = 0; bus2.player_y = 200;
      model_clear();
      m_speed = 4;
      repeat (3) @(posedge pclk);
      #1 rst = 0;

      // Reset values
      @(negedge pclk);
      chk("rst_active", bus.obj_active, 0);
      for (int i = 0; i < 4; i++) chk("rst_x", slot_x(i), 640);
      chk("rst_type", bus.obj_type, 0);
      chk("rst_score", bus.score, 0);
      chk("rst_speed", bus.speed, 4);
      chk("rst_hit", bus.hit, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_overrun", bus.overrun, 0);
      @(posedge pclk); #1;

      // First frame spawns slot 0 at 640
      bus.run = 1;
      send_frame(200, 0, 0, 0);
      chk("f1_active", bus.obj_active, 1);
      chk("f1_x0", slot_x(0), 640);
      chk("f1_score", bus.score, 0);

      // 200 frames airborne: spawns at frames 1,64,127,190; slot0 scores at 146, despawns at 172
      repeat (199) send_frame(200, 0, 0, 0);
      chk("f200_active", bus.obj_active, 4'b1110);
      chk("f200_score", bus.score, 1);
      chk("f200_x3", slot_x(3), 600);
      chk("f200_x1", slot_x(1), 96);
      chk("f200_hit", bus.hit, 0);

      // Player on the ground with slot1 at x=92: collision, sticky until clear
      send_frame(332, 0, 0, 0);
      chk("hit_set", bus.hit, 1);
      repeat (3) send_frame(200, 0, 0, 0);
      chk("hit_sticky", bus.hit, 1);
      pulse_clear();
      @(negedge pclk);
      chk("clr_hit", bus.hit, 0);
      chk("clr_active", bus.obj_active, 0);
      chk("clr_score", bus.score, 0);
      @(posedge pclk); #1;

      // Second tick 3 cycles into the walk: ignored, overrun flagged
      send_frame(200, 0, 1, 0);
      chk("ovr_flag", bus.overrun, 1);
      idle_busy_count(15, seen);
      chk("ovr_no_second_walk", seen, 0);

      // clear with frame_tick in the same cycle
      bus.clear = 1; bus.frame_tick = 1;
      @(posedge pclk); #1;
      bus.clear = 0; bus.frame_tick = 0;
      model_clear();
      idle_busy_count(12, seen);
      chk("clr_tick_busy", seen, 0);
      chk("clr_tick_overrun", bus.overrun, 0);
      chk("clr_tick_active", bus.obj_active, 0);

      // run drops mid-walk: walk completes; later ticks ignored without overrun
      send_frame(200, 0, 0, 1);
      chk("runlow_active", bus.obj_active, 1);
      bus.frame_tick = 1;
      @(posedge pclk); #1;
      bus.frame_tick = 0;
      idle_busy_count(15, seen);
      chk("runlow_busy", seen, 0);
      chk("runlow_overrun", bus.overrun, 0);
      bus.run = 1;

      // Type 3 obstacle against a grounded player
      pulse_clear();
      repeat (150) send_frame(332, 3, 0, 0);
      chk("fly_score", bus.score, 1);
      chk("fly_type0", bus.obj_type[1:0], 3);
      chk("fly_hit", bus.hit, FLY ? 0 : 1);

      // Small-score instance: score saturates at 15 and speed at 15
      bus2.run = 1;
      repeat (300) begin
         bus2.frame_tick = 1;
         @(posedge pclk); #1;
         bus2.frame_tick = 0;
         repeat (12) @(posedge pclk);
         #1;
      end
      @(negedge pclk);
      chk("sat_score", bus2.score, 15);
      chk("sat_speed", bus2.speed, 15);
      chk("sat_hit", bus2.hit, 0);
      chk("sb_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
